// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, key decode and a signed
// decimal operand accumulator for the calculator front end.
module keypad_entry #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        ovf
);

    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEB,
        S_PRESS
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] db_q, db_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [13:0]   mag_q, mag_d;
    logic          neg_q, neg_d;
    logic          fresh_q, fresh_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   value_q, value_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;

    logic          tick;
    logic [3:0]    low;
    logic          one_low;
    logic          match;
    logic          fire;
    logic [3:0]    key;
    logic [16:0]   cand;
    logic [16:0]   limit;
    logic [15:0]   mag16;

    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v[1]) r = 2'd1;
        if (v[2]) r = 2'd2;
        if (v[3]) r = 2'd3;
        return r;
    endfunction

    function automatic logic [3:0] keymap(input logic [1:0] r,
                                          input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign tick    = (cnt_q == CW'(SCAN_DIV - 1));
    assign low     = ~sync2_q;
    assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    assign match   = (sync2_q == ~(4'b0001 << ridx_q));
    assign key     = keymap(ridx_q, cidx_q);

    // Scan / debounce / release tracking
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        db_d    = db_q;
        cidx_d  = cidx_q;
        ridx_d  = ridx_q;
        fire    = 1'b0;
        unique case (state_q)
            S_SCAN: begin
                if (tick) begin
                    if (one_low) begin
                        ridx_d  = enc(low);
                        db_d    = '0;
                        state_d = S_DEB;
                    end else begin
                        cidx_d = cidx_q + 2'd1;
                    end
                end
            end
            S_DEB: begin
                if (tick) begin
                    if (!match) begin
                        state_d = S_SCAN;
                        cidx_d  = cidx_q + 2'd1;
                    end else if (db_q == DW'(DEBOUNCE - 1)) begin
                        state_d = S_PRESS;
                        db_d    = '0;
                        fire    = 1'b1;
                    end else begin
                        db_d = db_q + DW'(1);
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (sync2_q != 4'hF) begin
                        db_d = '0;
                    end else if (db_q == DW'(DEBOUNCE - 1)) begin
                        state_d = S_SCAN;
                        db_d    = '0;
                        cidx_d  = cidx_q + 2'd1;
                    end else begin
                        db_d = db_q + DW'(1);
                    end
                end
            end
        endcase
        col_d = ~(4'b0001 << cidx_d);
    end

    // Operand accumulator; mul-by-10 as shift-add, never wraps
    always_comb begin
        mag_d   = mag_q;
        neg_d   = neg_q;
        fresh_d = fresh_q;
        ovf_d   = ovf_q;
        code_d  = code_q;
        valid_d = fire;
        cand    = ({3'b0, mag_q} << 3) + ({3'b0, mag_q} << 1)
                + {13'b0, key};
        limit   = neg_q ? 17'd999 : 17'd9999;
        if (fire) begin
            code_d = key;
            if (key <= 4'd9) begin
                if (fresh_q) begin
                    mag_d   = {10'b0, key};
                    neg_d   = 1'b0;
                    fresh_d = 1'b0;
                end else if (cand <= limit) begin
                    mag_d = cand[13:0];
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (key == 4'hD) begin
                fresh_d = 1'b0;
                if (!neg_q && mag_q > 14'd999) ovf_d = 1'b1;
                else neg_d = ~neg_q;
            end else if (key == 4'hE) begin
                mag_d   = '0;
                neg_d   = 1'b0;
                ovf_d   = 1'b0;
                fresh_d = 1'b0;
            end else begin
                fresh_d = 1'b1;
            end
        end
        mag16   = {2'b0, mag_d};
        value_d = neg_d ? (16'd0 - mag16) : mag16;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_SCAN;
            cnt_q   <= '0;
            db_q    <= '0;
            cidx_q  <= 2'd0;
            ridx_q  <= 2'd0;
            col_q   <= 4'b1110;
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            fresh_q <= 1'b0;
            ovf_q   <= 1'b0;
            value_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            cidx_q  <= cidx_d;
            ridx_q  <= ridx_d;
            col_q   <= col_d;
            sync1_q <= row;
            sync2_q <= sync1_q;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            fresh_q <= fresh_d;
            ovf_q   <= ovf_d;
            value_q <= value_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign col       = col_q;
    assign value     = value_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: keypad model driven from col,
// key-sequence table plus bounce, dual-row and reset corner cases.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        ovf;

    logic        press_en = 1'b0;
    logic        bounce_hi = 1'b0;
    logic        dual_en = 1'b0;
    logic [1:0]  pr = 2'd0;
    logic [1:0]  pc = 2'd0;

    int checks = 0;
    int fails = 0;
    int pulses = 0;

    typedef struct {
        logic [3:0]  key;
        logic [3:0]  code;
        logic [15:0] val;
        logic        ov;
    } vec_t;

    vec_t vt[22];
    logic [3:0] kmap[16];

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .value(value),
        .key_code(key_code),
        .key_valid(key_valid),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        if (press_en && col == ~(4'b0001 << pc))
            row = bounce_hi ? 4'hF : ~(4'b0001 << pr);
        if (dual_en && col == 4'b1110)
            row = 4'b1100;
    end

    always @(negedge clk) if (key_valid) pulses++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_key(input logic [3:0] k);
        for (int i = 0; i < 16; i++)
            if (kmap[i] == k) begin
                pr = 2'(i / 4);
                pc = 2'(i % 4);
            end
    endtask

    task automatic wait_pulse(input int base, input string name);
        int n = 0;
        while (pulses == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (pulses == base) chk(name, 32'd0, 32'd1);
    endtask

    task automatic press_key(input logic [3:0] k);
        int base;
        base = pulses;
        set_key(k);
        press_en = 1'b1;
        wait_pulse(base, "press_timeout");
        repeat (10) @(negedge clk);
        press_en = 1'b0;
        repeat (30) @(negedge clk);
        chk("one_pulse", pulses - base, 32'd1);
    endtask

    task automatic wait_col(input logic [3:0] c, input logic eq);
        int n = 0;
        while (((col == c) != eq) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if ((col == c) != eq) chk("col_wait", {28'd0, col}, {28'd0, c});
    endtask

    initial begin
        logic [3:0] kinit[16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'hE, 4'h0, 4'hF, 4'hD};
        int base;
        logic [1:0] ci;
        kmap = kinit;
        vt[0]  = '{4'h1, 4'h1, 16'd1,    1'b0};
        vt[1]  = '{4'h2, 4'h2, 16'd12,   1'b0};
        vt[2]  = '{4'h3, 4'h3, 16'd123,  1'b0};
        vt[3]  = '{4'h4, 4'h4, 16'd1234, 1'b0};
        vt[4]  = '{4'h5, 4'h5, 16'd1234, 1'b1};
        vt[5]  = '{4'hE, 4'hE, 16'd0,    1'b0};
        vt[6]  = '{4'h9, 4'h9, 16'd9,    1'b0};
        vt[7]  = '{4'h9, 4'h9, 16'd99,   1'b0};
        vt[8]  = '{4'hD, 4'hD, 16'hFF9D, 1'b0};
        vt[9]  = '{4'h9, 4'h9, 16'hFC19, 1'b0};
        vt[10] = '{4'h9, 4'h9, 16'hFC19, 1'b1};
        vt[11] = '{4'hE, 4'hE, 16'd0,    1'b0};
        vt[12] = '{4'h1, 4'h1, 16'd1,    1'b0};
        vt[13] = '{4'h0, 4'h0, 16'd10,   1'b0};
        vt[14] = '{4'h0, 4'h0, 16'd100,  1'b0};
        vt[15] = '{4'h0, 4'h0, 16'd1000, 1'b0};
        vt[16] = '{4'hD, 4'hD, 16'd1000, 1'b1};
        vt[17] = '{4'hE, 4'hE, 16'd0,    1'b0};
        vt[18] = '{4'h4, 4'h4, 16'd4,    1'b0};
        vt[19] = '{4'h2, 4'h2, 16'd42,   1'b0};
        vt[20] = '{4'hA, 4'hA, 16'd42,   1'b0};
        vt[21] = '{4'h7, 4'h7, 16'd7,    1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", {28'd0, col}, 32'hE);
        chk("rst_value", {16'd0, value}, 32'd0);
        chk("rst_code", {28'd0, key_code}, 32'd0);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            ci = 2'((k / 4) % 4);
            chk("idle_col", {28'd0, col}, {28'd0, ~(4'b0001 << ci)});
        end
        chk("idle_pulses", pulses, 32'd0);

        for (int i = 0; i < 22; i++) begin
            press_key(vt[i].key);
            chk("tbl_code", {28'd0, key_code}, {28'd0, vt[i].code});
            chk("tbl_value", {16'd0, value}, {16'd0, vt[i].val});
            chk("tbl_ovf", {31'd0, ovf}, {31'd0, vt[i].ov});
        end

        // bounce on key 5, then stable low and a long hold
        base = pulses;
        set_key(4'h5);
        wait_col(4'b1101, 1'b0);
        wait_col(4'b1101, 1'b1);
        bounce_hi = 1'b0;
        press_en = 1'b1;
        repeat (4) @(negedge clk);
        bounce_hi = 1'b1;
        repeat (4) @(negedge clk);
        bounce_hi = 1'b0;
        wait_pulse(base, "bounce_timeout");
        repeat (100) @(negedge clk);
        chk("bounce_pulses", pulses - base, 32'd1);
        chk("bounce_code", {28'd0, key_code}, 32'h5);
        chk("bounce_value", {16'd0, value}, 32'd75);
        press_en = 1'b0;
        repeat (30) @(negedge clk);

        base = pulses;
        dual_en = 1'b1;
        repeat (80) @(negedge clk);
        dual_en = 1'b0;
        repeat (20) @(negedge clk);
        chk("dual_pulses", pulses - base, 32'd0);
        chk("dual_value", {16'd0, value}, 32'd75);

        // reset while debouncing key 1
        base = pulses;
        set_key(4'h1);
        wait_col(4'b1110, 1'b0);
        press_en = 1'b1;
        wait_col(4'b1110, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_col", {28'd0, col}, 32'hE);
        chk("mid_value", {16'd0, value}, 32'd0);
        chk("mid_code", {28'd0, key_code}, 32'd0);
        chk("mid_valid", {31'd0, key_valid}, 32'd0);
        chk("mid_ovf", {31'd0, ovf}, 32'd0);
        press_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_pulses", pulses - base, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
